// File: rtl/score_keeper.sv
// score_keeper: BCD win/draw counters with first-to-WIN_SCORE match detection.
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   clear      synchronous new-match clear
//   win_in     per-player win levels (edge detected internally)
//   draw_in    draw level (edge detected internally)
//   score_bcd  per-player BCD scores, player p at [p*DIGITS*4 +: DIGITS*4]
//   draws_bcd  BCD draw count
//   score_evt  one-cycle pulse when any counter changed
//   match_over high once a player reaches WIN_SCORE, until clear/reset
//   winner     one-hot match winner, valid while match_over
module score_keeper #(
    parameter int PLAYERS   = 2,
    parameter int DIGITS    = 2,
    parameter int WIN_SCORE = 5,
    parameter int SATURATE  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [PLAYERS-1:0]          win_in,
    input  logic                        draw_in,
    output logic [PLAYERS*DIGITS*4-1:0] score_bcd,
    output logic [DIGITS*4-1:0]         draws_bcd,
    output logic                        score_evt,
    output logic                        match_over,
    output logic [PLAYERS-1:0]          winner
);
    localparam int DW = DIGITS * 4;
    localparam logic [0:0] PLAY = 1'b0;
    localparam logic [0:0] OVER = 1'b1;

    function automatic logic [DW-1:0] to_bcd(input int n);
        logic [DW-1:0] v;
        int t;
        v = '0;
        t = n;
        for (int d = 0; d < DIGITS; d++) begin
            v[d*4+:4] = 4'(t % 10);
            t = t / 10;
        end
        return v;
    endfunction

    // Ripple a +1 through the digits; all nines rolls over to zero.
    function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (c) begin
                if (r[d*4+:4] == 4'd9) r[d*4+:4] = 4'd0;
                else begin
                    r[d*4+:4] = r[d*4+:4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [DW-1:0] MAX_BCD = to_bcd(10 ** DIGITS - 1);
    localparam logic [DW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    logic [PLAYERS*DW-1:0] score_q, score_d;
    logic [DW-1:0]         draws_q, draws_d;
    logic                  evt_q, evt_d;
    logic [0:0]            state_q, state_d;
    logic [PLAYERS-1:0]    winner_q, winner_d;
    logic [PLAYERS-1:0]    win_q;
    logic                  draw_q;
    logic [PLAYERS-1:0]    win_rise;
    logic                  draw_rise, one_win, any_rise;
    logic [DW-1:0]         cur, nxt;

    assign win_rise  = win_in & ~win_q;
    assign draw_rise = draw_in & ~draw_q;
    // Exactly one player rose and no draw: a clean win; anything else with a rise is a draw.
    assign one_win   = (win_rise != '0) && ((win_rise & (win_rise - PLAYERS'(1))) == '0) && !draw_rise;
    assign any_rise  = (win_rise != '0) || draw_rise;

    always_comb begin
        score_d  = score_q;
        draws_d  = draws_q;
        evt_d    = 1'b0;
        state_d  = state_q;
        winner_d = winner_q;
        cur      = '0;
        nxt      = '0;
        if (clear) begin
            score_d  = '0;
            draws_d  = '0;
            winner_d = '0;
            state_d  = PLAY;
        end else if (state_q == PLAY && one_win) begin
            for (int p = 0; p < PLAYERS; p++) begin
                if (win_rise[p]) begin
                    cur = score_q[p*DW+:DW];
                    nxt = bcd_inc(cur);
                    if (!(SATURATE != 0 && cur == MAX_BCD)) begin
                        score_d[p*DW+:DW] = nxt;
                        evt_d = 1'b1;
                        if (WIN_SCORE != 0 && nxt == WIN_BCD) begin
                            state_d     = OVER;
                            winner_d    = '0;
                            winner_d[p] = 1'b1;
                        end
                    end
                end
            end
        end else if (state_q == PLAY && any_rise) begin
            nxt = bcd_inc(draws_q);
            if (!(SATURATE != 0 && draws_q == MAX_BCD)) begin
                draws_d = nxt;
                evt_d   = 1'b1;
            end
        end
    end

    // Edge-detect history resets high so a level held across reset is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q  <= '0;
            draws_q  <= '0;
            evt_q    <= 1'b0;
            state_q  <= PLAY;
            winner_q <= '0;
            win_q    <= '1;
            draw_q   <= 1'b1;
        end else begin
            score_q  <= score_d;
            draws_q  <= draws_d;
            evt_q    <= evt_d;
            state_q  <= state_d;
            winner_q <= winner_d;
            win_q    <= win_in;
            draw_q   <= draw_in;
        end
    end

    assign score_bcd  = score_q;
    assign draws_bcd  = draws_q;
    assign score_evt  = evt_q;
    assign match_over = (state_q == OVER);
    assign winner     = winner_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: vector table plus scoreboard checks for score_keeper, with saturating and wrapping 1-digit instances.
module tb_score_keeper;
    logic        clk = 1'b0;
    logic        reset, clear, draw_in;
    logic [1:0]  win_in;
    logic [15:0] score_bcd;
    logic [7:0]  draws_bcd;
    logic        score_evt, match_over;
    logic [1:0]  winner;
    logic [7:0]  s_score, w_score;
    logic [3:0]  s_draws, w_draws;
    logic        s_evt, w_evt, s_over, w_over;
    logic [1:0]  s_win, w_win;

    typedef struct {
        logic [15:0] score;
        logic [7:0]  draws;
        logic        evt;
        logic        over;
        logic [1:0]  winner;
    } exp_t;

    typedef struct {
        logic [1:0] win;
        logic       draw;
        logic       clr;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[36];
    int   checks = 0;
    int   errors = 0;

    score_keeper dut (
        .clk(clk), .reset(reset), .clear(clear), .win_in(win_in), .draw_in(draw_in),
        .score_bcd(score_bcd), .draws_bcd(draws_bcd), .score_evt(score_evt),
        .match_over(match_over), .winner(winner)
    );

    score_keeper #(.PLAYERS(2), .DIGITS(1), .WIN_SCORE(0), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .win_in(win_in), .draw_in(draw_in),
        .score_bcd(s_score), .draws_bcd(s_draws), .score_evt(s_evt),
        .match_over(s_over), .winner(s_win)
    );

    score_keeper #(.PLAYERS(2), .DIGITS(1), .WIN_SCORE(0), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .win_in(win_in), .draw_in(draw_in),
        .score_bcd(w_score), .draws_bcd(w_draws), .score_evt(w_evt),
        .match_over(w_over), .winner(w_win)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input logic [15:0] s, input logic [7:0] d, input logic ev, input logic ov, input logic [1:0] w);
        exp_t e;
        e.score = s; e.draws = d; e.evt = ev; e.over = ov; e.winner = w;
        return e;
    endfunction

    function automatic vec_t mk(input logic [1:0] w, input logic d, input logic c, input exp_t e);
        vec_t v;
        v.win = w; v.draw = d; v.clr = c; v.e = e;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_main();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        cmp("score_bcd", 32'(score_bcd), 32'(e.score));
        cmp("draws_bcd", 32'(draws_bcd), 32'(e.draws));
        cmp("score_evt", 32'(score_evt), 32'(e.evt));
        cmp("match_over", 32'(match_over), 32'(e.over));
        cmp("winner", 32'(winner), 32'(e.winner));
    endtask

    task automatic step(input logic [1:0] w, input logic d, input logic c, input exp_t e);
        win_in = w; draw_in = d; clear = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_main();
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_score"}, 32'(score_bcd), 32'd0);
        cmp({tag, "_draws"}, 32'(draws_bcd), 32'd0);
        cmp({tag, "_evt"}, 32'(score_evt), 32'd0);
        cmp({tag, "_over"}, 32'(match_over), 32'd0);
        cmp({tag, "_winner"}, 32'(winner), 32'd0);
    endtask

    initial begin
        int m;
        tbl[0]  = mk(2'b00, 0, 0, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        tbl[1]  = mk(2'b01, 0, 0, ex(16'h0001, 8'h00, 1, 0, 2'b00));
        tbl[2]  = mk(2'b00, 0, 0, ex(16'h0001, 8'h00, 0, 0, 2'b00));
        tbl[3]  = mk(2'b01, 0, 0, ex(16'h0002, 8'h00, 1, 0, 2'b00));
        tbl[4]  = mk(2'b00, 0, 0, ex(16'h0002, 8'h00, 0, 0, 2'b00));
        tbl[5]  = mk(2'b01, 0, 0, ex(16'h0003, 8'h00, 1, 0, 2'b00));
        tbl[6]  = mk(2'b00, 0, 0, ex(16'h0003, 8'h00, 0, 0, 2'b00));
        tbl[7]  = mk(2'b00, 0, 1, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        tbl[8]  = mk(2'b11, 0, 0, ex(16'h0000, 8'h01, 1, 0, 2'b00));
        tbl[9]  = mk(2'b00, 0, 0, ex(16'h0000, 8'h01, 0, 0, 2'b00));
        tbl[10] = mk(2'b00, 1, 0, ex(16'h0000, 8'h02, 1, 0, 2'b00));
        tbl[11] = mk(2'b00, 0, 0, ex(16'h0000, 8'h02, 0, 0, 2'b00));
        tbl[12] = mk(2'b01, 1, 0, ex(16'h0000, 8'h03, 1, 0, 2'b00));
        tbl[13] = mk(2'b00, 0, 0, ex(16'h0000, 8'h03, 0, 0, 2'b00));
        tbl[14] = mk(2'b00, 0, 1, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        tbl[15] = mk(2'b10, 0, 0, ex(16'h0100, 8'h00, 1, 0, 2'b00));
        tbl[16] = mk(2'b00, 0, 0, ex(16'h0100, 8'h00, 0, 0, 2'b00));
        tbl[17] = mk(2'b10, 0, 0, ex(16'h0200, 8'h00, 1, 0, 2'b00));
        tbl[18] = mk(2'b00, 0, 0, ex(16'h0200, 8'h00, 0, 0, 2'b00));
        tbl[19] = mk(2'b10, 0, 0, ex(16'h0300, 8'h00, 1, 0, 2'b00));
        tbl[20] = mk(2'b00, 0, 0, ex(16'h0300, 8'h00, 0, 0, 2'b00));
        tbl[21] = mk(2'b10, 0, 0, ex(16'h0400, 8'h00, 1, 0, 2'b00));
        tbl[22] = mk(2'b00, 0, 0, ex(16'h0400, 8'h00, 0, 0, 2'b00));
        tbl[23] = mk(2'b10, 0, 0, ex(16'h0500, 8'h00, 1, 1, 2'b10));
        tbl[24] = mk(2'b00, 0, 0, ex(16'h0500, 8'h00, 0, 1, 2'b10));
        tbl[25] = mk(2'b01, 0, 0, ex(16'h0500, 8'h00, 0, 1, 2'b10));
        tbl[26] = mk(2'b00, 0, 0, ex(16'h0500, 8'h00, 0, 1, 2'b10));
        tbl[27] = mk(2'b00, 1, 0, ex(16'h0500, 8'h00, 0, 1, 2'b10));
        tbl[28] = mk(2'b00, 0, 0, ex(16'h0500, 8'h00, 0, 1, 2'b10));
        tbl[29] = mk(2'b00, 0, 1, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        tbl[30] = mk(2'b00, 0, 0, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        tbl[31] = mk(2'b01, 0, 1, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        tbl[32] = mk(2'b01, 0, 0, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        tbl[33] = mk(2'b00, 0, 0, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        tbl[34] = mk(2'b01, 0, 0, ex(16'h0001, 8'h00, 1, 0, 2'b00));
        tbl[35] = mk(2'b00, 0, 0, ex(16'h0001, 8'h00, 0, 0, 2'b00));

        reset = 1'b1; clear = 1'b0; win_in = 2'b00; draw_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        foreach (tbl[i]) step(tbl[i].win, tbl[i].draw, tbl[i].clr, tbl[i].e);

        // Level held for ten cycles counts once.
        step(2'b00, 0, 1, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        step(2'b00, 0, 0, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        for (int i = 0; i < 10; i++) step(2'b01, 0, 0, ex(16'h0001, 8'h00, i == 0, 0, 2'b00));
        step(2'b00, 0, 0, ex(16'h0001, 8'h00, 0, 0, 2'b00));

        // Reset with win_in held high: no count until it falls and rises again.
        win_in = 2'b01;
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset_held");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) step(2'b01, 0, 0, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        step(2'b00, 0, 0, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        step(2'b01, 0, 0, ex(16'h0001, 8'h00, 1, 0, 2'b00));
        step(2'b00, 0, 0, ex(16'h0001, 8'h00, 0, 0, 2'b00));

        // Twelve p0 pulses: main instance stops at 5, 1-digit instances saturate/wrap.
        step(2'b00, 0, 1, ex(16'h0000, 8'h00, 0, 0, 2'b00));
        for (int i = 1; i <= 12; i++) begin
            m = (i < 5) ? i : 5;
            step(2'b01, 0, 0, ex(16'(m), 8'h00, i <= 5, i >= 5, (i >= 5) ? 2'b01 : 2'b00));
            cmp($sformatf("sat_score_%0d", i), 32'(s_score), (i <= 9) ? i : 9);
            cmp($sformatf("sat_evt_%0d", i), 32'(s_evt), 32'(i <= 9));
            cmp($sformatf("wrap_score_%0d", i), 32'(w_score), i % 10);
            cmp($sformatf("wrap_evt_%0d", i), 32'(w_evt), 32'd1);
            step(2'b00, 0, 0, ex(16'(m), 8'h00, 0, i >= 5, (i >= 5) ? 2'b01 : 2'b00));
        end
        cmp("sat_over", 32'(s_over), 32'd0);

        // OVER ignores p1, then asynchronous reset mid-cycle clears it without a clock edge.
        step(2'b10, 0, 0, ex(16'h0005, 8'h00, 0, 1, 2'b01));
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset_over");
        cmp("sat_reset", 32'(s_score), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
